// File: rtl/rda_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk per stage,
// with valid/ready flow control, bubble collapsing, a sideband tag, carry-out and signed overflow.
module rda_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int C = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : gen_width_check
    $error("rda_pipe_addsub: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] stage_rdy;
  logic [WIDTH-1:0]  stage_acc [STAGES];
  logic [WIDTH-1:0]  stage_bp  [STAGES];
  logic              stage_c   [STAGES];
  logic [TAG_W-1:0]  stage_tag [STAGES];

  logic              up_v     [STAGES];
  logic [WIDTH-1:0]  up_acc   [STAGES];
  logic [WIDTH-1:0]  up_bp    [STAGES];
  logic              up_c     [STAGES];
  logic [TAG_W-1:0]  up_tag   [STAGES];
  logic [C:0]        chunk    [STAGES];
  logic [WIDTH-1:0]  acc_next [STAGES];

  assign in_ready = stage_rdy[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      localparam int LO  = gi * C;
      localparam int REM = WIDTH - (gi + 1) * C;
      localparam logic [WIDTH-1:0] CHUNK_MASK = ({WIDTH{1'b1}} >> (WIDTH - C)) << LO;

      logic             v_reg;
      logic [WIDTH-1:0] acc_reg;
      logic             carry_reg;
      logic [TAG_W-1:0] tag_reg;

      if (gi == 0) begin : gen_head
        assign up_v[gi]   = in_valid;
        assign up_acc[gi] = a;
        assign up_bp[gi]  = sub ? ~b : b;
        assign up_c[gi]   = sub;
        assign up_tag[gi] = tag_in;
      end else begin : gen_link
        assign up_v[gi]   = v_vec[gi-1];
        assign up_acc[gi] = stage_acc[gi-1];
        assign up_bp[gi]  = stage_bp[gi-1];
        assign up_c[gi]   = stage_c[gi-1];
        assign up_tag[gi] = stage_tag[gi-1];
      end

      // Unrolled form of rdy_k = !v_k | rdy_(k+1): ready unless this stage and everything below is full.
      assign stage_rdy[gi] = out_ready || !(&v_vec[STAGES-1:gi]);

      assign chunk[gi]    = {1'b0, up_acc[gi][LO +: C]} + {1'b0, up_bp[gi][LO +: C]}
                          + {{C{1'b0}}, up_c[gi]};
      assign acc_next[gi] = (up_acc[gi] & ~CHUNK_MASK) | (WIDTH'(chunk[gi][C-1:0]) << LO);

      // Data only moves with a valid transaction so the outputs hold while idle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg     <= 1'b0;
          acc_reg   <= '0;
          carry_reg <= 1'b0;
          tag_reg   <= '0;
        end else if (stage_rdy[gi]) begin
          v_reg <= up_v[gi];
          if (up_v[gi]) begin
            acc_reg   <= acc_next[gi];
            carry_reg <= chunk[gi][C];
            tag_reg   <= up_tag[gi];
          end
        end
      end

      assign v_vec[gi]     = v_reg;
      assign stage_acc[gi] = acc_reg;
      assign stage_c[gi]   = carry_reg;
      assign stage_tag[gi] = tag_reg;

      if (REM > 0) begin : gen_bp
        logic [REM-1:0] bp_reg;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            bp_reg <= '0;
          end else if (stage_rdy[gi] && up_v[gi]) begin
            bp_reg <= up_bp[gi][WIDTH-1 -: REM];
          end
        end
        assign stage_bp[gi] = {bp_reg, {(WIDTH-REM){1'b0}}};
      end else begin : gen_no_bp
        assign stage_bp[gi] = '0;
      end

      if (gi == STAGES - 1) begin : gen_tail
        logic msb_cin;
        logic ovf_reg;
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign msb_cin = up_acc[gi][WIDTH-1] ^ up_bp[gi][WIDTH-1] ^ chunk[gi][C-1];
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            ovf_reg <= 1'b0;
          end else if (stage_rdy[gi] && up_v[gi]) begin
            ovf_reg <= msb_cin ^ chunk[gi][C];
          end
        end
        assign ovf = ovf_reg;
      end
    end
  endgenerate

  assign out_valid = v_vec[STAGES-1];
  assign sum       = stage_acc[STAGES-1];
  assign cout      = stage_c[STAGES-1];
  assign tag_out   = stage_tag[STAGES-1];

endmodule

// File: tb/tb_rda_pipe_addsub.sv
// Bench for rda_pipe_addsub: directed vector table and corner sequences on a 32/4 instance,
// then randomized traffic on 32/4, 8/8 and 16/1 instances against an arithmetic reference model.
module tb_rda_pipe_addsub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [7:0]  tag;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [7:0]  t;
  } res_t;

  localparam int NT = 10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv [3];
  logic        irdy [3];
  logic        ordy [3];
  logic        ov [3];
  logic        sb [3];
  logic        co [3];
  logic        of [3];
  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic [7:0]  ti [3];
  logic [7:0]  to [3];
  logic [31:0] sum_w0;
  logic [7:0]  sum_w1;
  logic [15:0] sum_w2;

  int cw [3] = '{32, 8, 16};
  int n_checks = 0;
  int n_fail = 0;

  rda_pipe_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a_s[0]), .b(b_s[0]),
    .sub(sb[0]), .tag_in(ti[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum_w0),
    .cout(co[0]), .ovf(of[0]), .tag_out(to[0]));

  rda_pipe_addsub #(.WIDTH(8), .STAGES(8), .TAG_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a_s[1][7:0]), .b(b_s[1][7:0]),
    .sub(sb[1]), .tag_in(ti[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum_w1),
    .cout(co[1]), .ovf(of[1]), .tag_out(to[1]));

  rda_pipe_addsub #(.WIDTH(16), .STAGES(1), .TAG_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a_s[2][15:0]), .b(b_s[2][15:0]),
    .sub(sb[2]), .tag_in(ti[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum_w2),
    .cout(co[2]), .ovf(of[2]), .tag_out(to[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic res_t ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic s, input logic [7:0] t);
    longint ua, ub, sa, sbv, full, sres, lim;
    res_t r;
    ua  = longint'(a & wmask(w));
    ub  = longint'(b & wmask(w));
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - (lim << 1) : ua;
    sbv = (ub >= lim) ? ub - (lim << 1) : ub;
    if (s) begin
      full = ua - ub;
      r.c  = (ua >= ub);
      sres = sa - sbv;
    end else begin
      full = ua + ub;
      r.c  = (full >= (lim << 1));
      sres = sa + sbv;
    end
    r.s = 32'(full) & wmask(w);
    r.o = (sres >= lim) || (sres < -lim);
    r.t = t;
    return r;
  endfunction

  function automatic res_t dut_out(input int c);
    res_t r;
    case (c)
      0:       r.s = sum_w0;
      1:       r.s = {24'd0, sum_w1};
      default: r.s = {16'd0, sum_w2};
    endcase
    r.c = co[c];
    r.o = of[c];
    r.t = to[c];
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    iv[0] = 1'b1; a_s[0] = v.a; b_s[0] = v.b; sb[0] = v.sub; ti[0] = v.tag; ordy[0] = 1'b1;
    #1 chk({nm, "_in_ready"}, 64'(irdy[0]), 64'd1);
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_sum"}, 64'(sum_w0), 64'(v.es));
    chk({nm, "_cout"}, 64'(co[0]), 64'(v.ec));
    chk({nm, "_ovf"}, 64'(of[0]), 64'(v.eo));
    chk({nm, "_tag"}, 64'(to[0]), 64'(v.tag));
    $display("txn %s: a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d tag=%h lat=%0d",
             nm, v.a, v.b, v.sub, sum_w0, co[0], of[0], to[0], lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    logic [31:0] cap_a [6];
    logic [31:0] cap_b [6];
    logic        cap_s [6];
    logic [7:0]  cap_t [6];
    res_t fifo [3][64];
    int wr [3], rd [3], acc_n [3], got_n [3];
    int idx_in, idx_out, lat, stale;
    res_t e, g;

    tbl[0] = '{32'hFFFF_FFF6, 32'd10,       1'b0, 8'h6B, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'd352,       32'd18,       1'b0, 8'h01, 32'd370,       1'b0, 1'b0};
    tbl[2] = '{32'd4,         32'd10,       1'b1, 8'h02, 32'hFFFF_FFFA, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'd1,        1'b0, 8'h03, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'd1,        1'b1, 8'h04, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'd0,         32'd0,        1'b1, 8'h05, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'd1,        1'b0, 8'h06, 32'h0000_0000, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 8'h07, 32'h0000_0000, 1'b1, 1'b1};

    for (int c = 0; c < 3; c++) begin
      iv[c] = 1'b0; ordy[c] = 1'b1; a_s[c] = '0; b_s[c] = '0; sb[c] = 1'b0; ti[c] = '0;
      wr[c] = 0; rd[c] = 0; acc_n[c] = 0; got_n[c] = 0;
    end

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(ov[0]), 64'd0);
    chk("reset_sum", 64'(sum_w0), 64'd0);
    chk("reset_flags", {62'd0, co[0], of[0]}, 64'd0);
    chk("reset_tag", 64'(to[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("reset_in_ready", 64'(irdy[0]), 64'd1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: 352+18 then 4-10 on consecutive cycles.
    @(negedge clk);
    iv[0] = 1'b1; a_s[0] = tbl[1].a; b_s[0] = tbl[1].b; sb[0] = tbl[1].sub; ti[0] = tbl[1].tag;
    @(negedge clk);
    a_s[0] = tbl[2].a; b_s[0] = tbl[2].b; sb[0] = tbl[2].sub; ti[0] = tbl[2].tag;
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_sum", 64'(sum_w0), 64'd370);
    chk("b2b_first_tag", 64'(to[0]), 64'(tbl[1].tag));
    @(negedge clk);
    chk("b2b_second_valid", 64'(ov[0]), 64'd1);
    chk("b2b_second_sum", 64'(sum_w0), 64'hFFFF_FFFA);
    chk("b2b_second_cout", 64'(co[0]), 64'd0);
    $display("txn b2b: second result sum=%h cout=%0d tag=%h", sum_w0, co[0], to[0]);
    @(negedge clk);
    chk("b2b_drained", 64'(ov[0]), 64'd0);

    // Capacity with stalled consumer, then release with simultaneous push and pop.
    for (int i = 0; i < 6; i++) begin
      cap_a[i] = 32'h1000_0000 * i + 32'd17 * i + 32'd5;
      cap_b[i] = 32'd3 * i + 32'd1;
      cap_s[i] = i[0];
      cap_t[i] = 8'hA0 + 8'(i);
    end
    idx_in = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 60 && idx_out < 6; cyc++) begin
      @(negedge clk);
      ordy[0] = (cyc >= 6);
      iv[0] = (idx_in < 6);
      if (idx_in < 6) begin
        a_s[0] = cap_a[idx_in]; b_s[0] = cap_b[idx_in]; sb[0] = cap_s[idx_in]; ti[0] = cap_t[idx_in];
      end
      #1;
      if (cyc == 3) chk("cap_three_valid_in_ready", 64'(irdy[0]), 64'd1);
      if (cyc == 5) begin
        chk("cap_accepted", 64'(idx_in), 64'd4);
        chk("cap_full_in_ready", 64'(irdy[0]), 64'd0);
      end
      if (cyc == 6) chk("cap_push_pop_in_ready", 64'(irdy[0]), 64'd1);
      if (ov[0] && ordy[0]) begin
        e = ref_calc(32, cap_a[idx_out], cap_b[idx_out], cap_s[idx_out], cap_t[idx_out]);
        g = dut_out(0);
        chk($sformatf("cap_result%0d", idx_out), 64'(g), 64'(e));
        $display("txn cap%0d: sum=%h cout=%0d ovf=%0d tag=%h", idx_out, g.s, g.c, g.o, g.t);
        idx_out++;
      end
      if (iv[0] && irdy[0]) idx_in++;
    end
    chk("cap_all_out", 64'(idx_out), 64'd6);
    iv[0] = 1'b0;

    // Asynchronous reset with three transactions in flight.
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; a_s[0] = 32'h0101_0101 * (i + 1); b_s[0] = 32'd7; sb[0] = 1'b0; ti[0] = 8'h50 + 8'(i);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    #1 chk("rst_pre_valid", 64'(ov[0]), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", 64'(ov[0]), 64'd0);
    chk("rst_async_sum", 64'(sum_w0), 64'd0);
    chk("rst_async_tag", 64'(to[0]), 64'd0);
    chk("rst_async_flags", {62'd0, co[0], of[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ordy[0] = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    chk("rst_in_ready", 64'(irdy[0]), 64'd1);

    // Randomized traffic on all three configurations.
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (got_n[0] >= NT && got_n[1] >= NT && got_n[2] >= NT) break;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        iv[c]   = (acc_n[c] < NT) && ($urandom_range(3) != 0);
        ordy[c] = ($urandom_range(3) != 0);
        a_s[c]  = $urandom() & wmask(cw[c]);
        b_s[c]  = $urandom() & wmask(cw[c]);
        sb[c]   = $urandom_range(1) == 1;
        ti[c]   = 8'($urandom());
      end
      #1;
      for (int c = 0; c < 3; c++) begin
        if (ov[c] && ordy[c]) begin
          chk($sformatf("rand_c%0d_pending", c), 64'(wr[c] != rd[c]), 64'd1);
          g = dut_out(c);
          chk($sformatf("rand_c%0d_txn%0d", c, got_n[c]), 64'(g), 64'(fifo[c][rd[c] % 64]));
          rd[c]++;
          got_n[c]++;
        end
        if (iv[c] && irdy[c]) begin
          fifo[c][wr[c] % 64] = ref_calc(cw[c], a_s[c], b_s[c], sb[c], ti[c]);
          wr[c]++;
          acc_n[c]++;
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      iv[c] = 1'b0;
      chk($sformatf("rand_c%0d_count", c), 64'(got_n[c]), 64'(NT));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
